// File: rtl/ultrasonic_range_ctrl.sv
// Trigger/echo sequencer for an HC-SR04-style ultrasonic ranger.
// Fires the trigger, times the echo in centimetre steps and enforces the inter-shot hold-off.
module ultrasonic_range_ctrl #(
    parameter int TRIG_CYC    = 250,
    parameter int CM_CYC      = 1450,
    parameter int ECHO_TO_CYC = 750000,
    parameter int HOLDOFF_CYC = 1500000,
    parameter int MAX_CM      = 400,
    parameter int DW          = 9
) (
    input  logic          clk_in,
    input  logic          rst_n,
    input  logic          start,
    input  logic          auto_en,
    input  logic          echo,
    output logic          trig,
    output logic          busy,
    output logic          valid,
    output logic          timeout,
    output logic [DW-1:0] dist_cm
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RISE,
        S_MEASURE,
        S_HOLDOFF
    } state_t;

    // One shared counter times the trigger, the echo wait and the hold-off.
    localparam int CNT_MAX = (TRIG_CYC > ECHO_TO_CYC)
                           ? ((TRIG_CYC > HOLDOFF_CYC) ? TRIG_CYC : HOLDOFF_CYC)
                           : ((ECHO_TO_CYC > HOLDOFF_CYC) ? ECHO_TO_CYC : HOLDOFF_CYC);
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam int PS_W  = $clog2(CM_CYC + 1);

    localparam logic [CNT_W-1:0] TRIG_LAST  = CNT_W'(TRIG_CYC - 1);
    localparam logic [CNT_W-1:0] ECHO_LAST  = CNT_W'(ECHO_TO_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_CYC - 1);
    localparam logic [PS_W-1:0]  PRESC_LAST = PS_W'(CM_CYC - 1);
    localparam logic [DW-1:0]    MAX_CM_V   = DW'(MAX_CM);

    state_t          state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [PS_W-1:0]  presc, presc_nxt;
    logic [DW-1:0]    cm_cnt, cm_nxt;
    logic [DW-1:0]    dist_nxt;
    logic             trig_nxt, valid_nxt, timeout_nxt;

    logic echo_meta, echo_s, echo_q;
    logic echo_rise, echo_fall;

    // Echo is asynchronous: two flops for metastability, a third for edge detection.
    // NOTE: every flop here, synchroniser included, takes the async reset so no stale
    // echo level can fake an edge right after reset; there are no memories to exempt.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            echo_meta <= 1'b0;
            echo_s    <= 1'b0;
            echo_q    <= 1'b0;
        end else begin
            echo_meta <= echo;
            echo_s    <= echo_meta;
            echo_q    <= echo_s;
        end
    end

    assign echo_rise = echo_s & ~echo_q;
    assign echo_fall = ~echo_s & echo_q;

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            presc   <= '0;
            cm_cnt  <= '0;
            trig    <= 1'b0;
            valid   <= 1'b0;
            timeout <= 1'b0;
            dist_cm <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            presc   <= presc_nxt;
            cm_cnt  <= cm_nxt;
            trig    <= trig_nxt;
            valid   <= valid_nxt;
            timeout <= timeout_nxt;
            dist_cm <= dist_nxt;
        end
    end

    // NOTE: every signal is given its hold/default value first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        presc_nxt   = presc;
        cm_nxt      = cm_cnt;
        trig_nxt    = 1'b0;
        valid_nxt   = 1'b0;
        timeout_nxt = timeout;
        dist_nxt    = dist_cm;

        unique case (state)
            S_IDLE: begin
                if (start || auto_en) begin
                    state_nxt = S_TRIG;
                    trig_nxt  = 1'b1;
                    cnt_nxt   = '0;
                end
            end

            S_TRIG: begin
                if (cnt == TRIG_LAST) begin
                    state_nxt = S_WAIT_RISE;
                    cnt_nxt   = '0;
                end else begin
                    trig_nxt = 1'b1;
                    cnt_nxt  = cnt + 1'b1;
                end
            end

            // An echo already high on entry shows no rise until it has fallen first.
            S_WAIT_RISE: begin
                if (echo_rise) begin
                    state_nxt = S_MEASURE;
                    presc_nxt = '0;
                    cm_nxt    = '0;
                end else if (cnt == ECHO_LAST) begin
                    state_nxt   = S_HOLDOFF;
                    cnt_nxt     = '0;
                    valid_nxt   = 1'b1;
                    timeout_nxt = 1'b1;
                    dist_nxt    = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            // The fall test comes first so a fall coinciding with over-range wins.
            S_MEASURE: begin
                if (echo_fall) begin
                    state_nxt   = S_HOLDOFF;
                    cnt_nxt     = '0;
                    valid_nxt   = 1'b1;
                    timeout_nxt = 1'b0;
                    dist_nxt    = cm_cnt;
                end else if (presc == PRESC_LAST) begin
                    presc_nxt = '0;
                    if (cm_cnt == MAX_CM_V) begin
                        state_nxt   = S_HOLDOFF;
                        cnt_nxt     = '0;
                        valid_nxt   = 1'b1;
                        timeout_nxt = 1'b1;
                        dist_nxt    = MAX_CM_V;
                    end else begin
                        cm_nxt = cm_cnt + 1'b1;
                    end
                end else begin
                    presc_nxt = presc + 1'b1;
                end
            end

            S_HOLDOFF: begin
                if (cnt == HOLD_LAST) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_ultrasonic_range_ctrl.sv
// Directed and randomized bench for ultrasonic_range_ctrl with scaled-down timing.
// Expected results come from a plain-arithmetic model of echo width -> centimetres.
module tb_ultrasonic_range_ctrl;

    localparam int TRIG_CYC    = 10;
    localparam int CM_CYC      = 20;
    localparam int ECHO_TO_CYC = 500;
    localparam int HOLDOFF_CYC = 100;
    localparam int MAX_CM      = 40;
    localparam int DW          = 9;

    logic          clk_in  = 1'b0;
    logic          rst_n   = 1'b0;
    logic          start   = 1'b0;
    logic          auto_en = 1'b0;
    logic          echo    = 1'b0;
    logic          trig, busy, valid, timeout;
    logic [DW-1:0] dist_cm;

    ultrasonic_range_ctrl #(
        .TRIG_CYC   (TRIG_CYC),
        .CM_CYC     (CM_CYC),
        .ECHO_TO_CYC(ECHO_TO_CYC),
        .HOLDOFF_CYC(HOLDOFF_CYC),
        .MAX_CM     (MAX_CM),
        .DW         (DW)
    ) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .start  (start),
        .auto_en(auto_en),
        .echo   (echo),
        .trig   (trig),
        .busy   (busy),
        .valid  (valid),
        .timeout(timeout),
        .dist_cm(dist_cm)
    );

    always #5 clk_in = ~clk_in;

    int          checks    = 0;
    int          errors    = 0;
    int          cyc       = 0;
    int          valid_cnt = 0;
    int          valid_cyc = 0;
    logic [DW:0] last_res  = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // All sampling happens on the falling edge, away from the active edge.
    task automatic tick();
        @(negedge clk_in);
        cyc++;
        if (valid === 1'b1) begin
            valid_cnt++;
            valid_cyc = cyc;
            last_res  = {timeout, dist_cm};
        end
    endtask

    // width 0: echo never driven; width < 0: echo raised and left high.
    // The rise is recognised in the first high cycle; the remaining width-1 high
    // cycles are counted in whole centimetres until the fall is seen.
    function automatic logic [DW:0] model(input int width);
        int counted;
        if (width == 0) return {1'b1, DW'(0)};
        if (width < 0) return {1'b1, DW'(MAX_CM)};
        counted = width - 1;
        if (counted >= (MAX_CM + 1) * CM_CYC) return {1'b1, DW'(MAX_CM)};
        return {1'b0, DW'(counted / CM_CYC)};
    endfunction

    task automatic shot(input string tag, input bit use_start, input int gap, input int width,
                        input bit poke_start, input bit clr_auto,
                        output int trig_cyc, output int wait_len);
        int n;
        int v0;
        int t0;
        logic [DW:0] exp;
        exp = model(width);
        v0  = valid_cnt;
        if (use_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            check({tag, "_trig_on_next_edge"}, trig, 1);
            check({tag, "_busy_on_next_edge"}, busy, 1);
        end else begin
            n = 0;
            while (trig !== 1'b1 && n < 2 * HOLDOFF_CYC) begin
                tick();
                n++;
            end
            check({tag, "_auto_trig_seen"}, trig, 1);
        end
        trig_cyc = cyc;
        if (clr_auto) auto_en = 1'b0;
        n = 0;
        while (trig === 1'b1 && n < TRIG_CYC + 20) begin
            n++;
            tick();
        end
        check({tag, "_trig_len"}, n, TRIG_CYC);
        t0 = cyc;
        if (poke_start) begin
            repeat (3) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                tick();
            end
        end
        if (width != 0) begin
            repeat (gap) tick();
            echo = 1'b1;
            if (width > 0) begin
                repeat (width) tick();
                echo = 1'b0;
            end
        end
        n = 0;
        while (valid_cnt == v0 && n < ECHO_TO_CYC + (MAX_CM + 2) * CM_CYC + 100) begin
            tick();
            n++;
        end
        check({tag, "_valid_seen"}, valid_cnt > v0, 1);
        check({tag, "_result"}, last_res, exp);
        wait_len = valid_cyc - t0;
        n = 0;
        while (busy === 1'b1 && n < HOLDOFF_CYC + 20) begin
            tick();
            n++;
        end
        check({tag, "_holdoff_len"}, cyc - valid_cyc, HOLDOFF_CYC);
        check({tag, "_single_valid"}, valid_cnt - v0, 1);
    endtask

    task automatic expect_quiet(input string tag);
        int hi;
        hi = 0;
        repeat (40) begin
            tick();
            if (trig === 1'b1 || busy === 1'b1) hi++;
        end
        check(tag, hi, 0);
    endtask

    initial begin
        int tc;
        int tc_a;
        int tc_b;
        int wl;
        int n;

        repeat (3) tick();
        check("rst_trig", trig, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_timeout", timeout, 0);
        check("rst_dist", dist_cm, 0);
        rst_n = 1'b1;
        repeat (2) tick();
        check("idle_busy", busy, 0);

        shot("w507", 1, 3, CM_CYC * 25 + 7, 0, 0, tc, wl);
        shot("w19", 1, 5, 19, 0, 0, tc, wl);
        shot("noecho", 1, 0, 0, 0, 0, tc, wl);
        check("noecho_wait_len", wl, ECHO_TO_CYC);

        shot("stuck", 1, 2, -1, 0, 0, tc, wl);
        shot("held", 1, 0, 0, 0, 0, tc, wl);
        check("held_wait_len", wl, ECHO_TO_CYC);
        echo = 1'b0;
        repeat (5) tick();

        // Fall on the very cycle over-range would fire, then one cycle later.
        shot("w820", 1, 4, (MAX_CM + 1) * CM_CYC, 0, 0, tc, wl);
        shot("w821", 1, 4, (MAX_CM + 1) * CM_CYC + 1, 0, 0, tc, wl);

        shot("poke", 1, 4, 207, 1, 0, tc, wl);
        expect_quiet("start_not_queued");

        for (int i = 0; i < 8; i++) begin
            int k;
            int r;
            int g;
            k = $urandom_range(0, MAX_CM);
            r = $urandom_range(1, CM_CYC - 1);
            g = $urandom_range(0, 40);
            shot($sformatf("rand%0d", i), 1, g, k * CM_CYC + r, 0, 0, tc, wl);
        end

        auto_en = 1'b1;
        shot("auto_a", 0, 0, 0, 0, 0, tc_a, wl);
        shot("auto_b", 0, 0, 0, 0, 0, tc_b, wl);
        check("auto_spacing", tc_b - tc_a, TRIG_CYC + ECHO_TO_CYC + HOLDOFF_CYC + 1);
        shot("auto_c", 0, 6, 333, 1, 1, tc, wl);
        expect_quiet("auto_off_quiet");

        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_trig_trig", trig, 0);
        check("rst_mid_trig_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        tick();

        shot("pre_rst", 1, 2, CM_CYC * 25 + 7, 0, 0, tc, wl);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (trig === 1'b1 && n < TRIG_CYC + 20) begin
            tick();
            n++;
        end
        echo = 1'b1;
        repeat (100) tick();
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_meas_trig", trig, 0);
        check("rst_mid_meas_busy", busy, 0);
        check("rst_mid_meas_valid", valid, 0);
        check("rst_mid_meas_timeout", timeout, 0);
        check("rst_mid_meas_dist", dist_cm, 0);
        echo = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        shot("post_rst", 1, 3, CM_CYC * 7 + 11, 0, 0, tc, wl);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
